game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/dino_pkg.sv | 14 +
 rtl/game_ctrl_bcd_cnt4.sv | 36 +++
 rtl/game_ctrl.sv | 128 ++++++++++++
 tb/tb_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared constants and state encoding for the dino game controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int unsigned FRAMES_PER_POINT = 6;
  localparam int unsigned DEAD_LOCKOUT     = 30;
  localparam int unsigned SPEED_MAX        = 7;

endpackage

// File: rtl/game_ctrl_bcd_cnt4.sv
// Four-digit BCD up-counter that saturates at 9999; flags each step into a new hundred.
module bcd_cnt4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value,
  output logic        carry_hundreds
);

  logic [3:0]  carry;
  logic [15:0] value_nxt;

  always_comb begin
    carry[0] = inc && (value != 16'h9999);
    carry[1] = carry[0] && (value[3:0]  == 4'd9);
    carry[2] = carry[1] && (value[7:4]  == 4'd9);
    carry[3] = carry[2] && (value[11:8] == 4'd9);
    value_nxt = value;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry[i])
        value_nxt[4*i +: 4] = (value[4*i +: 4] == 4'd9) ? 4'd0 : value[4*i +: 4] + 4'd1;
    end
    carry_hundreds = carry[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else if (clr)
      value <= '0;
    else if (carry[0])
      value <= value_nxt;
  end

endmodule

// File: rtl/game_ctrl.sv
// Game state machine: frame pacing, collision latch, BCD scoring, speed and best score.
module game_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned FRAMES_PER_PT = dino_pkg::FRAMES_PER_POINT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        valid,
  input  logic        black_cactus,
  input  logic        black_dino,
  input  logic        start,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [2:0]  speed,
  output logic        hit
);

  localparam logic [2:0] FCNT_LAST = 3'(FRAMES_PER_PT - 1);
  localparam logic [4:0] LOCK_MAX  = 5'(DEAD_LOCKOUT);
  localparam logic [2:0] SPD_MAX   = 3'(SPEED_MAX);

  state_t     state_q, state_d;
  logic       vs_prev, frame_tick, overlap, latch, crash;
  logic [2:0] fcnt;
  logic [4:0] lock;
  logic       clr_game, inc_frame, enter_dead, score_inc, hund_carry;

  assign frame_tick = vsync && !vs_prev;
  assign overlap    = valid && black_cactus && black_dino;
  // an overlap on the tick cycle itself still counts for the frame just ended
  assign crash      = latch || overlap;
  assign score_inc  = inc_frame && (fcnt == FCNT_LAST);
  assign state      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    clr_game   = 1'b0;
    inc_frame  = 1'b0;
    enter_dead = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          clr_game = 1'b1;
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (crash) begin
            state_d    = DEAD;
            enter_dead = 1'b1;
          end else begin
            inc_frame = 1'b1;
          end
        end
      end
      DEAD: begin
        if (start && lock == LOCK_MAX) begin
          state_d  = RUN;
          clr_game = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev <= 1'b1;
      latch   <= 1'b0;
      hit     <= 1'b0;
    end else begin
      vs_prev <= vsync;
      if (frame_tick) begin
        hit   <= crash;
        latch <= 1'b0;
      end else if (overlap) begin
        latch <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt     <= '0;
      lock     <= '0;
      speed    <= 3'd1;
      hi_score <= '0;
    end else begin
      if (clr_game)
        fcnt <= '0;
      else if (inc_frame)
        fcnt <= (fcnt == FCNT_LAST) ? 3'd0 : fcnt + 3'd1;

      if (enter_dead)
        lock <= '0;
      else if (state_q == DEAD && frame_tick && lock != LOCK_MAX)
        lock <= lock + 5'd1;

      if (clr_game)
        speed <= 3'd1;
      else if (hund_carry && speed != SPD_MAX)
        speed <= speed + 3'd1;

      // packed BCD orders the same as binary, so a plain compare suffices
      if (enter_dead && score > hi_score)
        hi_score <= score;
    end
  end

  bcd_cnt4 u_score (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr_game),
    .inc            (score_inc),
    .value          (score),
    .carry_hundreds (hund_carry)
  );

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus randomized play against a score/frame reference model.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, vsync, valid, black_cactus, black_dino, start;
  logic [1:0]  state;
  logic [15:0] score, hi_score;
  logic [2:0]  speed;
  logic        hit;

  logic        vsync2, start2, zero;
  logic [1:0]  state2;
  logic [15:0] score2, hi_score2;
  logic [2:0]  speed2;
  logic        hit2;

  int checks = 0;
  int errors = 0;

  // reference model: plain integers following the game rules
  int m_state, m_score, m_hi, m_frames, m_lock;
  bit m_prev, m_latch, m_hit;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .valid(valid),
    .black_cactus(black_cactus), .black_dino(black_dino), .start(start),
    .state(state), .score(score), .hi_score(hi_score), .speed(speed), .hit(hit)
  );

  game_ctrl #(.FRAMES_PER_PT(1)) dut2 (
    .clk(clk), .rst(rst), .vsync(vsync2), .valid(zero),
    .black_cactus(zero), .black_dino(zero), .start(start2),
    .state(state2), .score(score2), .hi_score(hi_score2), .speed(speed2), .hit(hit2)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hi = 0; m_frames = 0; m_lock = 0;
    m_prev = 1'b1; m_latch = 1'b0; m_hit = 1'b0;
  endtask

  task automatic model_step();
    bit tk, crash;
    if (rst) begin
      model_reset();
      return;
    end
    tk    = vsync && !m_prev;
    crash = m_latch || (valid && black_cactus && black_dino);
    m_prev = vsync;
    case (m_state)
      0: if (start) begin m_state = 1; m_score = 0; m_frames = 0; end
      1: if (tk) begin
           if (crash) begin
             m_state = 2; m_lock = 0;
             if (m_score > m_hi) m_hi = m_score;
           end else begin
             m_frames++;
             if (m_frames % 6 == 0 && m_score < 9999) m_score++;
           end
         end
      default: begin
        if (start && m_lock >= 30) begin
          m_state = 1; m_score = 0; m_frames = 0;
        end else if (tk && m_lock < 30) m_lock++;
      end
    endcase
    if (tk) m_hit = crash;
    m_latch = tk ? 1'b0 : crash;
  endtask

  task automatic check_all();
    int sp;
    sp = 1 + m_score / 100;
    if (sp > 7) sp = 7;
    chk("state", 16'(state), 16'(m_state));
    chk("score", score, to_bcd(m_score));
    chk("hi_score", hi_score, to_bcd(m_hi));
    chk("speed", 16'(speed), 16'(sp));
    chk("hit", 16'(hit), 16'(m_hit));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_pix(input bit allow_ov);
    valid        = 1'($urandom_range(0, 1));
    black_cactus = 1'($urandom_range(0, 1));
    if (allow_ov) black_dino = ($urandom_range(0, 7) == 0);
    else          black_dino = black_cactus ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic frame(input bit allow_ov, input bit force_ov);
    int lo, hi;
    lo = $urandom_range(2, 5);
    hi = $urandom_range(1, 3);
    for (int i = 0; i < lo; i++) begin
      vsync = 1'b0;
      set_pix(allow_ov);
      if (force_ov && i == 1) begin valid = 1'b1; black_cactus = 1'b1; black_dino = 1'b1; end
      cyc();
    end
    for (int i = 0; i < hi; i++) begin
      vsync = 1'b1;
      set_pix(allow_ov);
      cyc();
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic press();
    start = 1'b1;
    set_pix(1'b0);
    cyc();
    start = 1'b0;
  endtask

  task automatic frames2(input int n);
    for (int i = 0; i < n; i++) begin
      vsync2 = 1'b0;
      @(posedge clk); @(negedge clk);
      vsync2 = 1'b1;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; valid = 1'b0; black_cactus = 1'b0; black_dino = 1'b0;
    start = 1'b0; vsync2 = 1'b1; start2 = 1'b0; zero = 1'b0;
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_speed", 16'(speed), 16'd1);
    chk("rst_score", score, 16'h0000);
    rst = 1'b0;

    // first game: 12 clean frames, then a collision
    frames(3);
    press();
    chk("run_entry", 16'(state), 16'd1);
    frames(12);
    chk("g1_state", 16'(state), 16'd1);
    chk("g1_score", score, 16'h0002);
    chk("g1_speed", 16'(speed), 16'd1);
    chk("g1_hit", 16'(hit), 16'd0);
    press();
    chk("start_in_run", 16'(state), 16'd1);
    frames(2);
    frame(1'b0, 1'b1);
    chk("crash_state", 16'(state), 16'd2);
    chk("crash_hit", 16'(hit), 16'd1);
    chk("crash_hi", hi_score, 16'h0002);
    frames(9);
    press();
    chk("lock_early", 16'(state), 16'd2);
    frames(20);
    press();
    chk("lock_29", 16'(state), 16'd2);
    frames(1);
    press();
    chk("lock_done_state", 16'(state), 16'd1);
    chk("lock_done_score", score, 16'h0000);

    // best-score tracking over three more games
    frames(252);
    chk("g2_score", score, 16'h0042);
    frame(1'b0, 1'b1);
    chk("g2_hi", hi_score, 16'h0042);
    frames(30); press();
    frames(60);
    frame(1'b0, 1'b1);
    chk("g3_hi_kept", hi_score, 16'h0042);
    frames(30); press();
    frames(258);
    frame(1'b0, 1'b1);
    chk("g4_hi_new", hi_score, 16'h0043);

    // randomized play
    for (int i = 0; i < 300; i++) begin
      frame($urandom_range(0, 3) == 0, 1'b0);
      if ($urandom_range(0, 4) == 0) press();
    end

    // overlap while idle, and start coinciding with a frame tick
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    frame(1'b0, 1'b1);
    chk("idle_hit", 16'(hit), 16'd1);
    chk("idle_state", 16'(state), 16'd0);
    frames(1);
    chk("idle_hit_clear", 16'(hit), 16'd0);
    vsync = 1'b0; set_pix(1'b0); cyc();
    vsync = 1'b1; start = 1'b1; set_pix(1'b0); cyc();
    start = 1'b0;
    chk("coinc_state", 16'(state), 16'd1);
    frames(5);
    chk("coinc_5", score, 16'h0000);
    frames(1);
    chk("coinc_6", score, 16'h0001);

    // asynchronous reset while dead
    frame(1'b0, 1'b1);
    chk("pre_rst_state", 16'(state), 16'd2);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("arst_state", 16'(state), 16'd0);
    chk("arst_score", score, 16'h0000);
    chk("arst_hi", hi_score, 16'h0000);
    chk("arst_speed", 16'(speed), 16'd1);
    chk("arst_hit", 16'(hit), 16'd0);
    @(negedge clk);
    cyc();
    rst = 1'b0;

    // one point per frame instance: hundreds carries and saturation
    start2 = 1'b1; @(posedge clk); @(negedge clk); start2 = 1'b0;
    chk("d2_state", 16'(state2), 16'd1);
    frames2(99);
    chk("d2_99", score2, 16'h0099);
    chk("d2_99_spd", 16'(speed2), 16'd1);
    frames2(1);
    chk("d2_100", score2, 16'h0100);
    chk("d2_100_spd", 16'(speed2), 16'd2);
    frames2(499);
    chk("d2_599_spd", 16'(speed2), 16'd6);
    frames2(1);
    chk("d2_600_spd", 16'(speed2), 16'd7);
    frames2(399);
    chk("d2_999", score2, 16'h0999);
    frames2(1);
    chk("d2_1000", score2, 16'h1000);
    chk("d2_1000_spd", 16'(speed2), 16'd7);
    frames2(8999);
    chk("d2_9999", score2, 16'h9999);
    frames2(12);
    chk("d2_sat", score2, 16'h9999);
    chk("d2_sat_state", 16'(state2), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
